keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Keypad scan controller for the safe-lock front end. It walks a one-cold column drive across a ROWS×COLS matrix keypad, advancing one step per scan tick from the system prescaler. It samples the active-low row lines, debounces a press over several scan ticks, and presents one key code per press to the code-entry logic using a valid/ack handshake. It then waits for a debounced release before scanning resumes.

## Interface
- COLS, 4, number of keypad columns (≥2)
- ROWS, 4, number of keypad rows (≥1)
- DEBOUNCE, 3, consecutive matching scan ticks required to accept a press or a release (≥1)
- KW, $clog2(ROWS*COLS), key_code width (4 at defaults)
- clk  input  1  system clock, 50 MHz
- reset  input  1  synchronous, active-high reset
- scan_tick  input  1  one-clk-wide pulse from the prescaler; period ≥4 clk
- row_in  input  ROWS  keypad rows, active-low, asynchronous to clk
- col_out  output  COLS  column drive, registered, one-cold (exactly one bit low)
- key_code  output  KW  row*COLS + col of the accepted key
- key_valid  output  1  key_code is valid; held until acknowledged
- key_ack  input  1  consumer accepts key_code

## Operation
- row_in passes through a 2-flop synchronizer. All sampling uses the synchronized value (row_s).
- Samples are taken only in cycles where scan_tick=1. The column in use has then been driven for the full tick period.
- Row hit: lowest-index row with row_s bit = 0. If several rows are low, the lowest row wins.
- States: SCAN, DEBOUNCE, PRESENT, WAIT_RELEASE.
- **SCAN**, on tick:
  - Row hit: latch cand_row, hold the column, set cnt=1, go to DEBOUNCE. If DEBOUNCE=1, go straight to PRESENT.
  - No hit: advance the column, wrapping COLS-1→0.
- **DEBOUNCE**, on tick, column held:
  - Hit with the same cand_row: cnt+1. When cnt reaches DEBOUNCE, register key_code and assert key_valid, then go to PRESENT.
  - No hit, or a different row: discard the candidate, advance the column, return to SCAN.
- **PRESENT**:
  - key_valid=1 and key_code are stable.
  - key_ack=1: key_valid=0 the next cycle, cnt=0, go to WAIT_RELEASE.
  - Ticks and row changes are ignored. A key released before ack is still delivered.
- **WAIT_RELEASE**, on tick, column held:
  - row_s all ones: cnt+1. When cnt reaches DEBOUNCE, advance the column and go to SCAN.
  - Any row low: cnt=0.
- key_ack while key_valid=0 is ignored.
- Exactly one key_valid assertion per debounced press. No auto-repeat.
- Counter width: $clog2(DEBOUNCE+1). cnt never exceeds DEBOUNCE.

## Timing
- Reset values:
  - col_out = all ones except bit 0 (4'b1110 at defaults)
  - key_valid = 0, key_code = 0
  - state = SCAN, cnt = 0, synchronizer flops = all ones
- reset overrides scan_tick and key_ack in the same cycle.
- Reset mid-operation (any state): all of the above values apply the cycle after reset. A pending key is dropped.
- col_out changes only in the cycle after a tick that advances the column. It is never all-ones and never has two bits low.
- Press latency: if the first matching sample is on tick T, key_valid rises the cycle after tick T+DEBOUNCE-1. Synchronizer delay adds 2 clk before a row change is visible.
- Ack completes in one cycle. key_valid and key_ack high on edge N means key_valid=0 after edge N.
- Earliest next scan: the cycle after the DEBOUNCE-th consecutive all-high tick in WAIT_RELEASE.

## Test plan
- **Reset and idle rotation.** Assert reset with a tick in the same cycle, then release; row_in=4'hF, ticks every 8 clk.
  - col_out=1110 immediately after reset.
  - Then 1101, 1011, 0111, 1110 on successive ticks. key_valid stays 0.
- **Clean press.** Hold row 2 low whenever col_out=1101 (col 1).
  - After 3 matching ticks: key_valid=1, key_code=9.
  - col_out held at 1101 until the key is released and acked.
- **Bounce rejection.** Row 2 at col 1 is low for 2 ticks, then high on the third.
  - No key_valid. The column advances to 1011 after the third tick.
- **Handshake and release.**
  - Delay ack by 20 clk: key_valid and key_code=9 stay stable throughout.
  - ack pulse: key_valid=0 the next cycle.
  - Key still held: no scanning.
  - After 3 all-high ticks, col_out=1011. Exactly one valid per press.
- **Multi-key.** Rows 1 and 3 both low at col 0.
  - key_code=4 (row 1 wins).
  - A spurious ack while key_valid=0 has no effect.
- **Reset mid-PRESENT.** Assert reset while key_valid=1.
  - Next cycle: key_valid=0, key_code=0, col_out=1110.
  - Scanning restarts cleanly.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Scans a ROWS x COLS matrix keypad for the safe-lock front end. A single
// low column walks across the keypad, one step per scan tick. The active-low
// rows are sampled on ticks and a press is debounced. One key code is then
// offered per press over a valid/ack handshake. A debounced release must
// follow before scanning resumes.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   scan_tick  one-cycle pulse from the prescaler; all sampling happens here
//   row_in     keypad rows, active-low, asynchronous to clk
//   col_out    registered one-cold column drive
//   key_code   row*COLS + col of the accepted key
//   key_valid  key_code is valid; held until key_ack
//   key_ack    consumer accepts key_code
module keypad_scan_ctrl #(
    parameter int COLS     = 4,
    parameter int ROWS     = 4,
    parameter int DEBOUNCE = 3,
    parameter int KW       = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            scan_tick,
    input  logic [ROWS-1:0] row_in,
    output logic [COLS-1:0] col_out,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ack
);

    localparam int CW = $clog2(COLS);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int NW = $clog2(DEBOUNCE + 1);
    localparam logic [NW-1:0] CNT_MAX  = NW'(DEBOUNCE);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESENT,
        ST_WAIT_RELEASE
    } state_t;

    state_t          state, state_next;
    logic [ROWS-1:0] row_meta, row_s;
    logic [CW-1:0]   col_idx, col_idx_next, col_adv;
    logic [COLS-1:0] col_out_next;
    logic [NW-1:0]   cnt, cnt_next, cnt_inc;
    logic [RW-1:0]   cand_row, cand_row_next;
    logic [KW-1:0]   key_code_next;
    logic            key_valid_next;
    logic            hit;
    logic [RW-1:0]   hit_row;

    // Lowest-index low row wins when several rows are pulled down at once.
    // The loop runs downwards so the last assignment is the lowest index.
    always_comb begin
        hit     = 1'b0;
        hit_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!row_s[i]) begin
                hit     = 1'b1;
                hit_row = RW'(i);
            end
        end
    end

    // Column wraps from the last column back to column 0.
    always_comb begin
        col_adv = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
        cnt_inc = cnt + 1'b1;
    end

    // Next-state logic. Ticks only matter outside PRESENT. The column is held
    // while a candidate, a presented key or a pending release owns it.
    always_comb begin
        state_next     = state;
        col_idx_next   = col_idx;
        cnt_next       = cnt;
        cand_row_next  = cand_row;
        key_code_next  = key_code;
        key_valid_next = key_valid;

        case (state)
            ST_SCAN: begin
                if (scan_tick) begin
                    if (hit) begin
                        cand_row_next = hit_row;
                        cnt_next      = NW'(1);
                        if (DEBOUNCE == 1) begin
                            key_code_next  = KW'(int'(hit_row) * COLS + int'(col_idx));
                            key_valid_next = 1'b1;
                            state_next     = ST_PRESENT;
                        end else begin
                            state_next = ST_DEBOUNCE;
                        end
                    end else begin
                        col_idx_next = col_adv;
                    end
                end
            end

            ST_DEBOUNCE: begin
                if (scan_tick) begin
                    if (hit && (hit_row == cand_row)) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            key_code_next  = KW'(int'(cand_row) * COLS + int'(col_idx));
                            key_valid_next = 1'b1;
                            state_next     = ST_PRESENT;
                        end
                    end else begin
                        cnt_next     = '0;
                        col_idx_next = col_adv;
                        state_next   = ST_SCAN;
                    end
                end
            end

            ST_PRESENT: begin
                if (key_ack) begin
                    key_valid_next = 1'b0;
                    cnt_next       = '0;
                    state_next     = ST_WAIT_RELEASE;
                end
            end

            ST_WAIT_RELEASE: begin
                if (scan_tick) begin
                    if (!hit) begin
                        if (cnt_inc == CNT_MAX) begin
                            cnt_next     = '0;
                            col_idx_next = col_adv;
                            state_next   = ST_SCAN;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        cnt_next = '0;
                    end
                end
            end

            default: begin
                state_next = ST_SCAN;
            end
        endcase

        // Decode ahead of the register so col_out itself comes from a flop.
        for (int i = 0; i < COLS; i++) begin
            col_out_next[i] = (CW'(i) != col_idx_next);
        end
    end

    // State register and row synchronizer. Reset idles the synchronizer high
    // so no phantom press is seen right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta  <= '1;
            row_s     <= '1;
            state     <= ST_SCAN;
            col_idx   <= '0;
            col_out   <= {{(COLS - 1){1'b1}}, 1'b0};
            cnt       <= '0;
            cand_row  <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            row_meta  <= row_in;
            row_s     <= row_meta;
            state     <= state_next;
            col_idx   <= col_idx_next;
            col_out   <= col_out_next;
            cnt       <= cnt_next;
            cand_row  <= cand_row_next;
            key_code  <= key_code_next;
            key_valid <= key_valid_next;
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl
// Self-checking bench for keypad_scan_ctrl. A simulated key matrix pulls a row
// low whenever a pressed key's column is driven. A tick-level reference model
// tracks the expected column, debounce streaks and the handshake. Directed
// scenarios run first, followed by randomized presses, releases and acks.
module tb_keypad_scan_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DB   = 3;
    localparam int KW   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            scan_tick;
    logic            key_ack;
    logic [ROWS-1:0] row_in;
    logic [COLS-1:0] col_out;
    logic [KW-1:0]   key_code;
    logic            key_valid;

    logic [ROWS*COLS-1:0] pressed;

    int checks = 0;
    int errors = 0;
    int valid_edges = 0;
    bit check_en = 1'b0;
    logic prev_valid;

    // Reference model state, in tick-level terms
    int m_col;
    bit m_present;
    bit m_release;
    int m_streak;
    int m_streak_row;
    int m_rel;
    int m_code;
    int m_accepted = 0;

    keypad_scan_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .DEBOUNCE(DB), .KW(KW)
    ) dut (
        .clk(clk), .reset(reset), .scan_tick(scan_tick), .row_in(row_in),
        .col_out(col_out), .key_code(key_code), .key_valid(key_valid),
        .key_ack(key_ack)
    );

    always #10 clk = ~clk;

    // Key matrix: a pressed key shorts its row to its column, so the row reads
    // low while that column is driven low.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_in[r] = 1'b1;
            for (int c = 0; c < COLS; c++) begin
                if (pressed[r*COLS + c] && (col_out[c] == 1'b0)) row_in[r] = 1'b0;
            end
        end
    end

    // Counts rising edges of key_valid, i.e. deliveries seen by the consumer
    always_ff @(posedge clk) begin
        prev_valid <= key_valid;
        if (key_valid === 1'b1 && prev_valid === 1'b0) valid_edges <= valid_edges + 1;
    end

    function automatic int modelSample();
        int h = -1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (pressed[r*COLS + m_col]) h = r;
        end
        return h;
    endfunction

    function automatic logic [COLS-1:0] expCol();
        logic [COLS-1:0] v = '1;
        v[m_col] = 1'b0;
        return v;
    endfunction

    task automatic modelReset();
        m_col = 0; m_present = 0; m_release = 0;
        m_streak = 0; m_streak_row = 0; m_rel = 0; m_code = 0;
    endtask

    // One scan tick: a key is accepted after DB consecutive ticks that see the
    // same row on the same column. A release needs DB consecutive all-clear
    // ticks. A tick that breaks a streak moves scanning to the next column.
    task automatic modelTick();
        int h = modelSample();
        if (m_present) begin
            // ticks ignored while a key waits for the consumer
        end else if (m_release) begin
            if (h < 0) begin
                m_rel++;
                if (m_rel == DB) begin
                    m_release = 0;
                    m_rel     = 0;
                    m_col     = (m_col + 1) % COLS;
                end
            end else begin
                m_rel = 0;
            end
        end else if (h >= 0 && (m_streak == 0 || h == m_streak_row)) begin
            m_streak++;
            m_streak_row = h;
            if (m_streak == DB) begin
                m_present = 1;
                m_code    = h * COLS + m_col;
                m_streak  = 0;
                m_accepted++;
            end
        end else begin
            m_streak = 0;
            m_col    = (m_col + 1) % COLS;
        end
    endtask

    task automatic modelAck();
        if (m_present) begin
            m_present = 0;
            m_release = 1;
            m_rel     = 0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic checkAll();
        if (check_en) begin
            checkOutput("col_out", 32'(col_out), 32'(expCol()));
            checkOutput("key_valid", 32'(key_valid), 32'(m_present));
            checkOutput("key_code", 32'(key_code), 32'(m_code));
        end
    endtask

    // One clock: check what the last edge produced, then drive the next inputs
    task automatic applyStimulus(input bit tick, input bit ack);
        @(negedge clk);
        checkAll();
        scan_tick = tick;
        key_ack   = ack;
        if (tick) modelTick();
        if (ack) modelAck();
    endtask

    task automatic tickPeriod(input int idle, input int ack_pos);
        for (int i = 0; i < idle; i++) applyStimulus(1'b0, (i == ack_pos));
        applyStimulus(1'b1, 1'b0);
    endtask

    task automatic settle();
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic doReset(input bit tick);
        @(negedge clk);
        checkAll();
        reset     = 1'b1;
        scan_tick = tick;
        key_ack   = 1'b1;
        modelReset();
        @(negedge clk);
        check_en = 1'b1;
        checkAll();
        checkOutput("reset col_out", 32'(col_out), 32'h0000_000E);
        checkOutput("reset key_valid", 32'(key_valid), 32'h0);
        checkOutput("reset key_code", 32'(key_code), 32'h0);
        reset     = 1'b0;
        scan_tick = 1'b0;
        key_ack   = 1'b0;
    endtask

    initial begin
        logic [COLS-1:0] rot [4];
        int idle, ack_pos, r;
        rot[0] = 4'b1101; rot[1] = 4'b1011; rot[2] = 4'b0111; rot[3] = 4'b1110;
        pressed = '0; reset = 1'b0; scan_tick = 1'b0; key_ack = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);

        // Reset with a coincident tick, then idle rotation
        doReset(1'b1);
        for (int k = 0; k < 4; k++) begin
            tickPeriod(7, -1);
            settle();
            checkOutput("rotate col_out", 32'(col_out), 32'(rot[k]));
            checkOutput("rotate key_valid", 32'(key_valid), 32'h0);
        end

        // Bounce: key (2,1) seen on two ticks only
        pressed[2*COLS + 1] = 1'b1;
        repeat (3) tickPeriod(7, -1);
        pressed = '0;
        tickPeriod(7, -1);
        settle();
        checkOutput("bounce col_out", 32'(col_out), 32'h0000_000B);
        checkOutput("bounce key_valid", 32'(key_valid), 32'h0);

        // Clean press of key (2,1): three more columns to reach col 1, then 3 ticks
        pressed[2*COLS + 1] = 1'b1;
        repeat (6) tickPeriod(7, -1);
        settle();
        checkOutput("press key_valid", 32'(key_valid), 32'h1);
        checkOutput("press key_code", 32'(key_code), 32'h9);
        repeat (2) tickPeriod(7, -1);
        settle();
        checkOutput("press col held", 32'(col_out), 32'h0000_000D);

        // Handshake: ack delayed by 20 clk
        repeat (20) applyStimulus(1'b0, 1'b0);
        checkOutput("delayed key_valid", 32'(key_valid), 32'h1);
        checkOutput("delayed key_code", 32'(key_code), 32'h9);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("ack key_valid", 32'(key_valid), 32'h0);
        repeat (3) tickPeriod(7, -1);
        settle();
        checkOutput("held no scan", 32'(col_out), 32'h0000_000D);
        pressed = '0;
        repeat (3) tickPeriod(7, -1);
        settle();
        checkOutput("release col_out", 32'(col_out), 32'h0000_000B);
        checkOutput("one valid per press", 32'(valid_edges), 32'h1);

        // Multi-key at column 0: rows 1 and 3, plus a spurious ack
        pressed[1*COLS + 0] = 1'b1;
        pressed[3*COLS + 0] = 1'b1;
        repeat (3) tickPeriod(7, -1);
        tickPeriod(7, 3);
        tickPeriod(7, -1);
        settle();
        checkOutput("multi key_valid", 32'(key_valid), 32'h1);
        checkOutput("multi key_code", 32'(key_code), 32'h4);

        // Reset while a key is presented, then scanning restarts
        pressed = '0;
        doReset(1'b0);
        repeat (2) tickPeriod(7, -1);
        settle();
        checkOutput("restart col_out", 32'(col_out), 32'h0000_000B);
        checkOutput("restart key_valid", 32'(key_valid), 32'h0);

        // Randomized presses, releases and acks
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 19);
            if (r < 2) pressed = '0;
            else if (r < 4) pressed = (ROWS*COLS)'(1) << $urandom_range(0, ROWS*COLS - 1);
            else if (r == 4) begin
                pressed = '0;
                pressed[$urandom_range(0, ROWS*COLS - 1)] = 1'b1;
                pressed[$urandom_range(0, ROWS*COLS - 1)] = 1'b1;
            end
            idle    = $urandom_range(3, 7);
            ack_pos = ($urandom_range(0, 2) == 0) ? $urandom_range(0, idle - 1) : -1;
            tickPeriod(idle, ack_pos);
        end
        settle();
        settle();
        checkOutput("valid pulse count", 32'(valid_edges), 32'(m_accepted));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
